param_datapath: RTL and testbench

PARAM_DATAPATH -- requirements
Module: param_datapath

---
 rtl/param_datapath.sv | 190 +++++++++++++++++++
 tb/tb_param_datapath.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_datapath.sv
// param_datapath: LC-3 style bus datapath (PC/IR/MAR/MDR, R0..R7, NZP/BEN)
// with a timed memory handshake FSM (IDLE -> BUSY -> DONE).
// Optional: define PARAM_DATAPATH_HEX_DEBUG_EN to drive HEX0..HEX3 with IR
// nibbles; otherwise the HEX outputs are tied low.
module param_datapath #(
  parameter int WIDTH       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_MAR,
  input  logic             LD_MDR,
  input  logic             LD_IR,
  input  logic             LD_BEN,
  input  logic             LD_CC,
  input  logic             LD_REG,
  input  logic             LD_PC,
  input  logic             GatePC,
  input  logic             GateMDR,
  input  logic             GateALU,
  input  logic             GateMARMUX,
  input  logic [1:0]       ALUK,
  input  logic             SR1MUX,
  input  logic             SR2MUX,
  input  logic             DRMUX,
  input  logic             ADDR1MUX,
  input  logic [1:0]       ADDR2MUX,
  input  logic [1:0]       PCMUX,
  input  logic             MEM_START,
  input  logic             MEM_WE,
  input  logic [WIDTH-1:0] Mem_Rdata,
  input  logic             Mem_Ready,
  output logic [WIDTH-1:0] Mem_Addr,
  output logic [WIDTH-1:0] Mem_Wdata,
  output logic             Mem_Valid,
  output logic             Mem_We,
  output logic             MEM_DONE,
  output logic             MEM_ERR,
  output logic             BEN,
  output logic             BUS_ERR,
  output logic [WIDTH-1:0] IR,
  output logic [WIDTH-1:0] PC,
  output logic [3:0]       HEX0,
  output logic [3:0]       HEX1,
  output logic [3:0]       HEX2,
  output logic [3:0]       HEX3
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_e;

  // last wait count before the transaction is abandoned
  localparam logic [15:0] CNT_LAST = 16'(MEM_TIMEOUT - 1);

  mem_state_e       state, state_nxt;
  logic [15:0]      cnt;
  logic             start, timeout, rd_done;

  logic [WIDTH-1:0] mar, mdr;
  logic [WIDTH-1:0] regs [8];
  logic [2:0]       nzp;

  logic [2:0]       sr1_idx, dr_idx;
  logic [WIDTH-1:0] sr1_val, opb, alu, imm5, off6, pc9, pc11;
  logic [WIDTH-1:0] addr1, addr2, addr_sum, bus, pc_nxt;
  logic             multi_gate;

  // operand selection, ALU, address adder, bus and next-PC
  always_comb begin
    sr1_idx = SR1MUX ? IR[8:6] : IR[11:9];
    dr_idx  = DRMUX ? 3'b111 : IR[11:9];
    imm5    = {{(WIDTH-5){IR[4]}},   IR[4:0]};
    off6    = {{(WIDTH-6){IR[5]}},   IR[5:0]};
    pc9     = {{(WIDTH-9){IR[8]}},   IR[8:0]};
    pc11    = {{(WIDTH-11){IR[10]}}, IR[10:0]};
    sr1_val = regs[sr1_idx];
    opb     = SR2MUX ? imm5 : regs[IR[2:0]];
    case (ALUK)
      2'b00:   alu = sr1_val + opb;
      2'b01:   alu = sr1_val & opb;
      2'b10:   alu = ~sr1_val;
      default: alu = sr1_val;
    endcase
    addr1 = ADDR1MUX ? sr1_val : PC;
    case (ADDR2MUX)
      2'b00:   addr2 = '0;
      2'b01:   addr2 = off6;
      2'b10:   addr2 = pc9;
      default: addr2 = pc11;
    endcase
    addr_sum = addr1 + addr2;
    // wired-OR bus: contention is flagged, not arbitrated
    bus = ({WIDTH{GatePC}}     & PC)
        | ({WIDTH{GateMDR}}    & mdr)
        | ({WIDTH{GateALU}}    & alu)
        | ({WIDTH{GateMARMUX}} & addr_sum);
    multi_gate = $countones({GatePC, GateMDR, GateALU, GateMARMUX}) > 1;
    case (PCMUX)
      2'b00:   pc_nxt = PC + 1'b1;
      2'b01:   pc_nxt = bus;
      2'b10:   pc_nxt = addr_sum;
      default: pc_nxt = PC;
    endcase
  end

  // architectural registers; a completing read owns MDR over LD_MDR
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      PC      <= '0;
      IR      <= '0;
      mar     <= '0;
      mdr     <= '0;
      nzp     <= 3'b010;
      BEN     <= 1'b0;
      BUS_ERR <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (LD_PC)  PC  <= pc_nxt;
      if (LD_IR)  IR  <= bus;
      if (LD_MAR) mar <= bus;
      if (rd_done)     mdr <= Mem_Rdata;
      else if (LD_MDR) mdr <= bus;
      if (LD_REG) regs[dr_idx] <= bus;
      if (LD_CC)  nzp <= {bus[WIDTH-1], bus == '0, !bus[WIDTH-1] && (bus != '0)};
      if (LD_BEN) BEN <= |(IR[11:9] & nzp);
      if (multi_gate) BUS_ERR <= 1'b1;
    end
  end

  // memory FSM next state; Mem_Ready wins over a same-cycle timeout
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    timeout   = 1'b0;
    rd_done   = 1'b0;
    case (state)
      IDLE: if (MEM_START) begin
        state_nxt = BUSY;
        start     = 1'b1;
      end
      BUSY: if (Mem_Ready) begin
        state_nxt = DONE;
        rd_done   = !Mem_We;
      end else if (cnt == CNT_LAST) begin
        state_nxt = IDLE;
        timeout   = 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // memory FSM state, wait counter and latched transaction fields
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      Mem_Addr  <= '0;
      Mem_Wdata <= '0;
      Mem_We    <= 1'b0;
      MEM_ERR   <= 1'b0;
    end else begin
      state   <= state_nxt;
      MEM_ERR <= timeout;
      if (start) begin
        cnt       <= '0;
        Mem_Addr  <= mar;
        Mem_Wdata <= mdr;
        Mem_We    <= MEM_WE;
      end else if (state == BUSY) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  assign Mem_Valid = (state == BUSY);
  assign MEM_DONE  = (state == DONE);

`ifdef PARAM_DATAPATH_HEX_DEBUG_EN
  assign HEX0 = IR[3:0];
  assign HEX1 = IR[7:4];
  assign HEX2 = IR[11:8];
  assign HEX3 = IR[15:12];
`else
  assign HEX0 = 4'h0;
  assign HEX1 = 4'h0;
  assign HEX2 = 4'h0;
  assign HEX3 = 4'h0;
`endif

endmodule

// File: tb/tb_param_datapath.sv
// tb_param_datapath: random datapath ops against a behavioural model plus
// directed memory handshake, timeout, reset and WIDTH=32 address cases.
module tb_param_datapath;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
  logic gate_pc, gate_mdr, gate_alu, gate_marmux;
  logic [1:0] aluk, addr2mux, pcmux;
  logic sr1mux, sr2mux, drmux, addr1mux;
  logic mem_start, mem_we, mem_ready;
  logic [31:0] mem_rdata;

  logic [15:0] mem_addr, mem_wdata, ir, pc;
  logic mem_valid, mem_we_o, mem_done, mem_err, ben, bus_err;
  logic [3:0] hex0, hex1, hex2, hex3;

  logic [31:0] m32_addr, m32_wdata, ir32, pc32;
  logic m32_valid, m32_we, m32_done, m32_err, ben32, buserr32;
  logic [3:0] h32_0, h32_1, h32_2, h32_3;

  int n_chk = 0;
  int n_bad = 0;

  // behavioural model state (16-bit DUT)
  logic [15:0] m_pc, m_ir, m_mar, m_mdr;
  logic [15:0] m_r [8];
  logic [2:0]  m_nzp;
  logic        m_ben, m_buserr;

  always #5 clk = ~clk;

  param_datapath #(.WIDTH(16), .MEM_TIMEOUT(4)) u_dut (
    .Clk(clk), .Reset(reset),
    .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
    .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc),
    .GatePC(gate_pc), .GateMDR(gate_mdr), .GateALU(gate_alu), .GateMARMUX(gate_marmux),
    .ALUK(aluk), .SR1MUX(sr1mux), .SR2MUX(sr2mux), .DRMUX(drmux), .ADDR1MUX(addr1mux),
    .ADDR2MUX(addr2mux), .PCMUX(pcmux), .MEM_START(mem_start), .MEM_WE(mem_we),
    .Mem_Rdata(mem_rdata[15:0]), .Mem_Ready(mem_ready),
    .Mem_Addr(mem_addr), .Mem_Wdata(mem_wdata), .Mem_Valid(mem_valid), .Mem_We(mem_we_o),
    .MEM_DONE(mem_done), .MEM_ERR(mem_err), .BEN(ben), .BUS_ERR(bus_err),
    .IR(ir), .PC(pc), .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3)
  );

  param_datapath #(.WIDTH(32), .MEM_TIMEOUT(4)) u_dut32 (
    .Clk(clk), .Reset(reset),
    .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
    .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc),
    .GatePC(gate_pc), .GateMDR(gate_mdr), .GateALU(gate_alu), .GateMARMUX(gate_marmux),
    .ALUK(aluk), .SR1MUX(sr1mux), .SR2MUX(sr2mux), .DRMUX(drmux), .ADDR1MUX(addr1mux),
    .ADDR2MUX(addr2mux), .PCMUX(pcmux), .MEM_START(mem_start), .MEM_WE(mem_we),
    .Mem_Rdata(mem_rdata), .Mem_Ready(mem_ready),
    .Mem_Addr(m32_addr), .Mem_Wdata(m32_wdata), .Mem_Valid(m32_valid), .Mem_We(m32_we),
    .MEM_DONE(m32_done), .MEM_ERR(m32_err), .BEN(ben32), .BUS_ERR(buserr32),
    .IR(ir32), .PC(pc32), .HEX0(h32_0), .HEX1(h32_1), .HEX2(h32_2), .HEX3(h32_3)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc} = '0;
    {gate_pc, gate_mdr, gate_alu, gate_marmux} = '0;
    {sr1mux, sr2mux, drmux, addr1mux} = '0;
    aluk = '0; addr2mux = '0; pcmux = '0;
    mem_start = 0; mem_we = 0; mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0;
    m_nzp = 3'b010; m_ben = 0; m_buserr = 0;
    for (int i = 0; i < 8; i++) m_r[i] = 0;
  endtask

  // two's-complement value of the low 'bits' of val, as 16 bits
  function automatic logic [15:0] sx(input int val, input int bits);
    int v;
    v = val;
    if (v >= (1 << (bits - 1))) v -= (1 << bits);
    return 16'(v);
  endfunction

  // one clock of the datapath as described by its register-transfer rules
  task automatic model_step();
    logic [15:0] a, b, alu, off, addr, bus, npc;
    int ngate;
    a = m_r[sr1mux ? m_ir[8:6] : m_ir[11:9]];
    b = sr2mux ? sx(int'(m_ir[4:0]), 5) : m_r[m_ir[2:0]];
    case (aluk)
      2'd0: alu = a + b;
      2'd1: alu = a & b;
      2'd2: alu = ~a;
      default: alu = a;
    endcase
    case (addr2mux)
      2'd0: off = 0;
      2'd1: off = sx(int'(m_ir[5:0]), 6);
      2'd2: off = sx(int'(m_ir[8:0]), 9);
      default: off = sx(int'(m_ir[10:0]), 11);
    endcase
    addr = (addr1mux ? a : m_pc) + off;
    bus = 0;
    if (gate_pc)     bus |= m_pc;
    if (gate_mdr)    bus |= m_mdr;
    if (gate_alu)    bus |= alu;
    if (gate_marmux) bus |= addr;
    ngate = int'(gate_pc) + int'(gate_mdr) + int'(gate_alu) + int'(gate_marmux);
    case (pcmux)
      2'd0: npc = m_pc + 16'd1;
      2'd1: npc = bus;
      2'd2: npc = addr;
      default: npc = m_pc;
    endcase
    if (ngate > 1) m_buserr = 1;
    if (ld_ben) m_ben = |(m_ir[11:9] & m_nzp);
    if (ld_cc)  m_nzp = bus[15] ? 3'b100 : ((bus == 0) ? 3'b010 : 3'b001);
    if (ld_reg) m_r[drmux ? 3'd7 : m_ir[11:9]] = bus;
    if (ld_pc)  m_pc = npc;
    if (ld_mar) m_mar = bus;
    if (ld_mdr) m_mdr = bus;
    if (ld_ir)  m_ir = bus;
  endtask

  task automatic step();
    model_step();
    tick();
    idle_inputs();
  endtask

  task automatic apply_reset();
    idle_inputs();
    #2 reset = 0;
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_flags", {ben, bus_err, mem_valid, mem_done, mem_err}, 0);
    tick();
    reset = 1;
    model_reset();
  endtask

  // full memory transaction; 'disturb' drives LD_MAR/LD_MDR/MEM_START during BUSY
  task automatic mem_xact(input logic we, input logic [31:0] rdata, input int waits,
                          input logic disturb);
    logic [15:0] exp_addr, exp_wdata;
    int vcnt;
    exp_addr = m_mar; exp_wdata = m_mdr; vcnt = 0;
    idle_inputs();
    mem_start = 1; mem_we = we;
    tick();
    for (int i = 0; i <= waits; i++) begin
      idle_inputs();
      mem_we = ~we;
      vcnt += int'(mem_valid);
      chk("busy_addr", mem_addr, exp_addr);
      chk("busy_wdata", mem_wdata, exp_wdata);
      chk("busy_we", mem_we_o, we);
      chk("busy_done", mem_done, 0);
      if (disturb) begin gate_pc = 1; ld_mar = 1; ld_mdr = 1; mem_start = 1; end
      if (i == waits) begin mem_ready = 1; mem_rdata = rdata; end
      model_step();
      if (i == waits && !we) m_mdr = rdata[15:0];
      tick();
    end
    chk("valid_cycles", vcnt, waits + 1);
    chk("done_pulse", {mem_done, mem_valid}, 2'b10);
    idle_inputs();
    mem_start = 1;
    tick();
    chk("done_clear", {mem_done, mem_valid, mem_err}, 0);
    idle_inputs();
  endtask

  // expose MDR on PC through the bus
  task automatic peek_mdr(input string tag);
    gate_mdr = 1; pcmux = 2'd1; ld_pc = 1;
    step();
    chk(tag, pc, m_pc);
  endtask

  initial begin
    logic [15:0] exp_hex;
    idle_inputs();
    model_reset();
    #2;
    apply_reset();

    // read with 3 wait cycles from MAR=3000
    mem_xact(0, 32'h3000, 0, 0);
    gate_mdr = 1; ld_mar = 1; step();
    mem_xact(0, 32'hBEEF, 3, 0);
    chk("mdr_beef_model", m_mdr, 16'hBEEF);
    peek_mdr("mdr_beef");
    mem_xact(0, 32'h1234, 2, 1);
    peek_mdr("mdr_override");
    mem_xact(1, 32'h5555, 1, 0);
    peek_mdr("mdr_after_write");

    // PC+1 wraps
    mem_xact(0, 32'hFFFF, 0, 0);
    peek_mdr("pc_ffff");
    pcmux = 2'd0; ld_pc = 1; step();
    chk("pc_wrap", pc, 16'h0000);

    // condition codes and branch enable
    mem_xact(0, 32'h0DFF, 0, 0);
    gate_mdr = 1; ld_ir = 1; step();
    mem_xact(0, 32'h8000, 0, 0);
    gate_mdr = 1; ld_cc = 1; step();
    ld_ben = 1; step();
    chk("ben_set", ben, 1);
    chk("nzp_model", m_nzp, 3'b100);

    // timeout: no Mem_Ready
    mem_start = 1; tick(); idle_inputs();
    for (int i = 0; i < 4; i++) begin
      chk("to_busy", {mem_valid, mem_err, mem_done}, 3'b100);
      mem_start = 1;
      tick();
    end
    idle_inputs();
    chk("to_err", {mem_valid, mem_err, mem_done}, 3'b010);
    tick();
    chk("to_err_clear", {mem_valid, mem_err, mem_done}, 0);
    peek_mdr("to_mdr_kept");

    // randomized datapath operations
    for (int n = 0; n < 400; n++) begin
      idle_inputs();
      case ($urandom_range(0, 4))
        1: gate_pc = 1;
        2: gate_mdr = 1;
        3: gate_alu = 1;
        4: gate_marmux = 1;
        default: ;
      endcase
      {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc} = 7'($urandom);
      aluk = 2'($urandom); addr2mux = 2'($urandom); pcmux = 2'($urandom);
      {sr1mux, sr2mux, drmux, addr1mux} = 4'($urandom);
      step();
      chk("rnd_pc", pc, m_pc);
      chk("rnd_ir", ir, m_ir);
      chk("rnd_ben", ben, m_ben);
      chk("rnd_buserr", bus_err, m_buserr);
`ifdef PARAM_DATAPATH_HEX_DEBUG_EN
      exp_hex = m_ir;
`else
      exp_hex = 16'h0;
`endif
      chk("rnd_hex", {hex3, hex2, hex1, hex0}, exp_hex);
    end
    mem_xact(0, 32'h0042, 1, 0);

    // bus contention is sticky until reset
    gate_pc = 1; gate_alu = 1; step();
    chk("buserr_set", bus_err, 1);
    tick(); tick();
    chk("buserr_sticky", bus_err, 1);
    apply_reset();
    chk("buserr_clear", bus_err, 0);

    // reset in BUSY aborts with no later pulse
    mem_start = 1; tick(); idle_inputs();
    chk("abort_busy", mem_valid, 1);
    #2 reset = 0;
    #1;
    chk("abort_valid", mem_valid, 0);
    @(posedge clk); #1;
    reset = 1; model_reset();
    mem_ready = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_quiet", {mem_valid, mem_done, mem_err}, 0);
    end
    idle_inputs();

    // WIDTH=32 address sum: PC=0x10 plus PCoffset9 of 0x1FF
    apply_reset();
    mem_xact(0, 32'h10, 0, 0);
    peek_mdr("pc_10");
    mem_xact(0, 32'h1FF, 0, 0);
    gate_mdr = 1; ld_ir = 1; step();
    pcmux = 2'd2; addr2mux = 2'd2; addr1mux = 0; ld_pc = 1; step();
    chk("addr_sum16", pc, 16'h000F);
    chk("addr_sum32", pc32, 32'h0000_000F);
    chk("ir32", ir32, 32'h0000_01FF);
    chk("w32_mem", {m32_addr, m32_wdata}, {32'h0, 32'h10});
    chk("w32_flags", {m32_valid, m32_we, m32_done, m32_err, ben32, buserr32}, 0);
`ifdef PARAM_DATAPATH_HEX_DEBUG_EN
    exp_hex = 16'h01FF;
`else
    exp_hex = 16'h0;
`endif
    chk("w32_hex", {h32_3, h32_2, h32_1, h32_0}, exp_hex);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1);
  end

endmodule
